// File: rtl/spi_log_uart.sv
// Log byte serializer: synchronizes log_strobe from the spi_clk domain, buffers
// bytes in a small FIFO and sends them as back-to-back 8N1 UART frames.
module spi_log_uart #(
  parameter int CLK_DIV = 217,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               log_strobe,
  input  logic [7:0]         log_val,
  output logic               uart_tx,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
);

  localparam int             DEPTH     = 1 << FIFO_AW;
  localparam logic [15:0]    BAUD_LOAD = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] ONE      = (FIFO_AW+1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  logic push_req, push_ok, pop, fifo_empty, fifo_full, baud_done;
  logic [7:0] head;

  assign push_req   = s2 & ~s3;
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == FULL_LVL);
  assign baud_done  = (baud_cnt == '0);
  assign head       = mem[rd_ptr[FIFO_AW-1:0]];
  // Pop only from IDLE or on the very last STOP cycle so frames chain without a gap.
  assign pop        = !fifo_empty && (state == IDLE || (state == STOP && baud_done));
  assign push_ok    = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= log_strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ONE;
      if (pop)     rd_ptr <= rd_ptr + ONE;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + ONE;
        2'b01:   fifo_level <= fifo_level - ONE;
        default: fifo_level <= fifo_level;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // When full, the write slot equals the read slot; the pop still sees the old byte.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= log_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= head;
            bit_cnt  <= '0;
            baud_cnt <= BAUD_LOAD;
            uart_tx  <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= BAUD_LOAD;
            uart_tx  <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_cnt == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= shreg >> 1;
              uart_tx <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            if (pop) begin
              shreg    <= head;
              bit_cnt  <= '0;
              baud_cnt <= BAUD_LOAD;
              uart_tx  <= 1'b0;
              state    <= START;
            end else begin
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_log_uart.sv
// Randomized bench for spi_log_uart: a queue/frame-time model predicts every
// output each cycle, a line decoder recovers bytes, and literal checks pin the model.
module tb_spi_log_uart;
  localparam int DIV   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          log_strobe = 1'b0;
  logic [7:0]    log_val = 8'h00;
  logic          uart_tx, tx_busy, overflow;
  logic [AW:0]   fifo_level;

  always #5 clk = ~clk;

  spi_log_uart #(.CLK_DIV(DIV), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .log_strobe(log_strobe), .log_val(log_val),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_level(fifo_level), .overflow(overflow)
  );

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0, rx_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: byte queue plus "time into current frame".
  logic [7:0] mq[$];
  logic [7:0] m_frame = 8'h00;
  bit         m_busy = 0, m_ovf = 0;
  int         m_t = 0;
  logic [2:0] hist = '0;  // strobe samples from 1, 2, 3 edges ago
  logic       e_tx = 1'b1, e_busy = 1'b0, e_ovf = 1'b0;
  int         e_level = 0;

  function automatic logic line_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return d[idx-1];
  endfunction

  always @(posedge clk) begin
    bit push, pop, last;
    if (reset) begin
      mq.delete();
      m_busy = 0; m_t = 0; m_ovf = 0; hist = '0;
    end else begin
      push = hist[1] && !hist[2];
      last = m_busy && (m_t == FRAME - 1);
      pop  = (mq.size() > 0) && (!m_busy || last);
      if (pop) begin
        m_frame = mq.pop_front(); m_busy = 1; m_t = 0;
      end else if (m_busy) begin
        if (last) m_busy = 0; else m_t++;
      end
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(log_val); else m_ovf = 1;
      end
      hist = {hist[1:0], log_strobe};
    end
    e_tx    = m_busy ? line_bit(m_frame, m_t / DIV) : 1'b1;
    e_busy  = m_busy;
    e_level = mq.size();
    e_ovf   = m_ovf;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("uart_tx", uart_tx, e_tx);
      chk("tx_busy", tx_busy, e_busy);
      chk("fifo_level", fifo_level, e_level);
      chk("overflow", overflow, e_ovf);
    end
  end

  // Line decoder: recovers bytes from uart_tx independently of the model.
  logic [7:0] rxq[$];
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (rx_en && uart_tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          d[i] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        chk("stop_bit", uart_tx, 1'b1);
        rxq.push_back(d);
      end
    end
  end

  // Busy-run and level-peak monitor for the burst test.
  int busy_cnt = 0, busy_rises = 0, peak = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (tx_busy === 1'b1) busy_cnt++;
    if (tx_busy === 1'b1 && prev_busy !== 1'b1) busy_rises++;
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
    prev_busy = tx_busy;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic [7:0] b, input int hi, input int lo);
    log_val = b; log_strobe = 1'b1;
    repeat (hi) tick();
    log_strobe = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((tx_busy !== 1'b0 || fifo_level !== '0) && n < budget) begin
      tick(); n++;
    end
    chk("idle_within_budget", n < budget, 1'b1);
    repeat (4) tick();
  endtask

  task automatic chk_rx(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, rxq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rxq.size(); i++)
      chk({name, "_byte"}, rxq[i], exp[i]);
  endtask

  initial begin
    logic [9:0] pat;
    logic [7:0] exp[$];
    logic [7:0] b;

    repeat (3) tick();
    chk_en = 1;
    chk("reset_tx", uart_tx, 1'b1);
    chk("reset_busy", tx_busy, 1'b0);
    chk("reset_level", fifo_level, 0);
    chk("reset_ovf", overflow, 1'b0);
    reset = 1'b0;
    rx_en = 1;
    repeat (3) tick();

    // Single byte 0xA5: exact latency and line pattern.
    rxq.delete();
    pat = 10'b1_1010_0101_0;
    log_val = 8'hA5; log_strobe = 1'b1;
    tick();                                    // edge N
    chk("a5_level_n", fifo_level, 0);
    tick();                                    // N+1
    log_strobe = 1'b0;
    chk("a5_level_n1", fifo_level, 0);
    tick();                                    // N+2
    chk("a5_level_n2", fifo_level, 1);
    chk("a5_tx_n2", uart_tx, 1'b1);
    tick();                                    // N+3
    chk("a5_level_n3", fifo_level, 0);
    for (int i = 0; i < FRAME; i++) begin
      chk("a5_line", uart_tx, pat[i / DIV]);
      chk("a5_busy", tx_busy, 1'b1);
      tick();
    end
    chk("a5_busy_end", tx_busy, 1'b0);
    chk("a5_tx_end", uart_tx, 1'b1);
    wait_idle(200);
    exp = '{8'hA5};
    chk_rx("a5_rx", exp);

    // Burst of three at 8-cycle spacing: one contiguous 120-cycle busy run.
    rxq.delete(); busy_cnt = 0; busy_rises = 0; peak = 0;
    strobe(8'h9F, 3, 5);
    strobe(8'h20, 3, 5);
    strobe(8'hBA, 3, 5);
    wait_idle(400);
    chk("burst_busy_cycles", busy_cnt, 120);
    chk("burst_busy_runs", busy_rises, 1);
    chk("burst_peak_level", peak, 2);
    exp = '{8'h9F, 8'h20, 8'hBA};
    chk_rx("burst_rx", exp);

    // Long strobe: one push only.
    rxq.delete();
    strobe(8'h5A, 50, 5);
    wait_idle(400);
    exp = '{8'h5A};
    chk_rx("long_rx", exp);

    // Wrap: 40 bytes one at a time through the FIFO.
    rxq.delete(); exp.delete();
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      exp.push_back(b);
      strobe(b, 2, 2);
      wait_idle(200);
    end
    chk_rx("wrap_rx", exp);
    chk("wrap_ovf", overflow, 1'b0);

    // Overflow: 7 strobes during the first frame, depth 4.
    rxq.delete(); exp.delete();
    for (int i = 0; i < 7; i++) begin
      b = 8'($urandom);
      if (i < 5) exp.push_back(b);
      strobe(b, 2, 2);
    end
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1'b1);
    wait_idle(600);
    chk_rx("ovf_rx", exp);
    chk("ovf_sticky", overflow, 1'b1);

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 40; i++)
      strobe(8'($urandom), $urandom_range(2, 5), $urandom_range(2, 25));
    wait_idle(5000);

    // Reset mid-frame with 3 bytes buffered.
    rx_en = 0;
    for (int i = 0; i < 4; i++) strobe(8'($urandom), 2, 2);
    chk("rst_pre_level", fifo_level, 3);
    chk("rst_pre_busy", tx_busy, 1'b1);
    reset = 1'b1;
    tick();
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk("rst_quiet_tx", uart_tx, 1'b1);
      tick();
    end
    rxq.delete();
    rx_en = 1;
    strobe(8'h3C, 2, 2);
    wait_idle(200);
    exp = '{8'h3C};
    chk_rx("post_rst_rx", exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
